pdm_multi_channel: RTL and testbench

//  Parametrised successor to the single-channel 5-bit PDM generator.
//  - NCH independent first-order sigma-delta PDM channels, each WIDTH bits deep.
//  - Levels are written through a shared channel-addressed write port into shadow registers.
//  - Shadows are committed glitch-free at a common frame boundary (every 2^WIDTH cycles).
//  - Drives the audio/LED PDM pins of the tile.

---
 rtl/pdm_multi_channel.sv | 101 ++++++++++
 tb/tb_pdm_multi_channel.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_multi_channel.sv
// Multi-channel first-order sigma-delta PDM generator with shadowed, frame-aligned level commits.
// Optional PDM_FRAME_STB_EN adds a registered frame_stb pulse one cycle after each commit.
module pdm_multi_channel #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CHW   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_chan,
  input  logic [WIDTH-1:0] wr_data,
  output logic [NCH-1:0]   pdm_out,
  output logic [NCH-1:0]   pending
`ifdef PDM_FRAME_STB_EN
  ,
  output logic             frame_stb
`endif
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [WIDTH-1:0] active_q [NCH];
  logic [WIDTH-1:0] active_d [NCH];
  logic [WIDTH-1:0] acc_q    [NCH];
  logic [WIDTH-1:0] acc_d    [NCH];
  logic [WIDTH:0]   sum      [NCH];
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   pdm_q, pdm_d;
  logic             frame_end;
  logic             commit;

  assign frame_end = (cnt_q == {WIDTH{1'b1}});
  // While stopped there is no frame to protect, so pending levels commit immediately.
  assign commit    = en ? frame_end : 1'b1;

  always_comb begin
    cnt_d     = en ? cnt_q + WIDTH'(1) : '0;
    pending_d = pending_q;
    pdm_d     = '0;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (commit && pending_q[i]) begin
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end
      // Only channels 0..NCH-1 can match, so out-of-range writes fall through untouched.
      // A write in the commit cycle wins over the clear and waits for the next boundary.
      if (wr_en && (wr_chan == CHW'(i))) begin
        shadow_d[i]  = wr_data;
        pending_d[i] = 1'b1;
      end
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, active_q[i]};
      acc_d[i] = en ? sum[i][WIDTH-1:0] : '0;
      pdm_d[i] = en & sum[i][WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pending_q <= '0;
      pdm_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        acc_q[i]    <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pdm_q     <= pdm_d;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        acc_q[i]    <= acc_d[i];
      end
    end
  end

  assign pdm_out = pdm_q;
  assign pending = pending_q;

`ifdef PDM_FRAME_STB_EN
  logic stb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stb_q <= 1'b0;
    end else begin
      stb_q <= en & frame_end;
    end
  end

  assign frame_stb = stb_q;
`endif

endmodule

// File: tb/tb_pdm_multi_channel.sv
// Scoreboard bench for pdm_multi_channel: a 2-channel and a 1-channel instance on one clock.
// Expectations are queued per cycle and checked by a negedge monitor.
module tb_pdm_multi_channel;

  localparam int W = 5;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         en      = 1'b0;
  logic         wr_en   = 1'b0;
  logic [0:0]   wr_chan = '0;
  logic [W-1:0] wr_data = '0;
  logic [1:0]   pdm_out;
  logic [1:0]   pending;
  logic         w1_en   = 1'b0;
  logic [0:0]   w1_chan = '0;
  logic [W-1:0] w1_data = '0;
  logic [0:0]   pdm1;
  logic [0:0]   pend1;
`ifdef PDM_FRAME_STB_EN
  logic         stb;
  logic         stb1;
`endif

  pdm_multi_channel #(.WIDTH(W), .NCH(2), .CHW(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .wr_en   (wr_en),
    .wr_chan (wr_chan),
    .wr_data (wr_data),
    .pdm_out (pdm_out),
    .pending (pending)
`ifdef PDM_FRAME_STB_EN
    ,
    .frame_stb (stb)
`endif
  );

  pdm_multi_channel #(.WIDTH(W), .NCH(1), .CHW(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .wr_en   (w1_en),
    .wr_chan (w1_chan),
    .wr_data (w1_data),
    .pdm_out (pdm1),
    .pending (pend1)
`ifdef PDM_FRAME_STB_EN
    ,
    .frame_stb (stb1)
`endif
  );

  always #5 clk = ~clk;

  // kind: 0 pdm_out, 1 pending, 2 ones in last 32 samples of channel ch,
  //       3 frame_stb (ch selects instance), 4 single-channel pending, 5 single-channel ones
  typedef struct {
    int    due;
    int    kind;
    int    ch;
    int    exp;
    string name;
  } chk_t;

  chk_t        sb[$];
  int          cyc   = 0;
  int          tcnt  = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] hist0 = '0;
  logic [31:0] hist1 = '0;
  logic [31:0] hists = '0;

  // {ch1,ch0} at cnt=1..11 after en rises with levels 26 / 15 and acc cleared
  int seq [11] = '{0, 1, 3, 1, 3, 0, 3, 1, 3, 1, 2};

  function automatic void chk(string name, int kind, int ch, int exp);
    chk_t e;
    e.due  = cyc;
    e.kind = kind;
    e.ch   = ch;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endfunction

  function automatic int actual(int kind, int ch);
    case (kind)
      0: return int'(pdm_out);
      1: return int'(pending);
      2: return (ch == 1) ? $countones(hist1) : $countones(hist0);
`ifdef PDM_FRAME_STB_EN
      3: return (ch == 1) ? int'(stb1) : int'(stb);
`endif
      4: return int'(pend1);
      5: return $countones(hists);
      default: return -1;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    hist0 = {hist0[30:0], pdm_out[0]};
    hist1 = {hist1[30:0], pdm_out[1]};
    hists = {hists[30:0], pdm1[0]};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        int a;
        a = actual(sb[i].kind, sb[i].ch);
        n_cmp++;
        if (a != sb[i].exp) begin
          n_bad++;
          $display("FAIL %s (cyc %0d): actual %0d, required %0d", sb[i].name, cyc, a, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!reset || !en) tcnt = 0;
    else tcnt = (tcnt + 1) % 32;
    cyc++;
    #1;
    wr_en = 1'b0;
    w1_en = 1'b0;
  endtask

  task automatic wait_cnt(int k);
    for (int i = 0; i < 64 && tcnt != k; i++) tick();
  endtask

  task automatic wr(int ch, int data);
    wr_en   = 1'b1;
    wr_chan = 1'(ch);
    wr_data = W'(data);
  endtask

  task automatic wr1(int ch, int data);
    w1_en   = 1'b1;
    w1_chan = 1'(ch);
    w1_data = W'(data);
  endtask

  initial begin
    tick();
    tick();
    n_cmp++;
    if (pdm_out !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_pdm_direct: actual %b, required 00", pdm_out);
    end
    n_cmp++;
    if (pending !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_pend_direct: actual %b, required 00", pending);
    end
    chk("rst_pdm", 0, 0, 0);
    chk("rst_pend", 1, 0, 0);
    chk("rst_pend1", 4, 0, 0);
`ifdef PDM_FRAME_STB_EN
    chk("rst_stb", 3, 0, 0);
`endif
    reset = 1'b1;
    en    = 1'b1;

    // Idle run, no writes
    repeat (64) begin
      tick();
      n_cmp++;
      if (pdm_out !== 2'b00) begin
        n_bad++;
        $display("FAIL idle_pdm_direct (cyc %0d): actual %b, required 00", cyc, pdm_out);
      end
      n_cmp++;
      if (pending !== 2'b00) begin
        n_bad++;
        $display("FAIL idle_pend_direct (cyc %0d): actual %b, required 00", cyc, pending);
      end
      chk("idle_pdm", 0, 0, 0);
      chk("idle_pend", 1, 0, 0);
    end

    // ch0 = 8 written at cnt=3
    wait_cnt(3);
    wr(0, 8);
    tick();
    chk("l8_pend_early", 1, 0, 1);
    wait_cnt(31);
    chk("l8_pend_late", 1, 0, 1);
    tick();
    chk("l8_pend_cleared", 1, 0, 0);
    chk("l8_pdm_cnt0", 0, 0, 0);
`ifdef PDM_FRAME_STB_EN
    chk("stb_after_commit", 3, 0, 1);
`endif
    tick();
`ifdef PDM_FRAME_STB_EN
    chk("stb_one_cycle", 3, 0, 0);
`endif
    repeat (3) tick();
    chk("l8_pdm_cnt4", 0, 0, 1);
    tick();
    chk("l8_pdm_cnt5", 0, 0, 0);
    wait_cnt(0);
    chk("l8_ones_ch0", 2, 0, 8);
    chk("l8_ones_ch1", 2, 1, 0);
    tick();
    wait_cnt(0);
    chk("l8_ones_stable", 2, 0, 8);

    // ch0 = 0x1a and ch1 = 0x04 in one frame
    wait_cnt(5);
    wr(0, 26);
    wait_cnt(9);
    wr(1, 4);
    tick();
    chk("two_pend_early", 1, 0, 3);
    wait_cnt(31);
    chk("two_pend_late", 1, 0, 3);
    tick();
    chk("two_pend_cleared", 1, 0, 0);
    tick();
    wait_cnt(0);
    chk("ones_26", 2, 0, 26);
    chk("ones_4", 2, 1, 4);

    // ch1 = 0x0f written in the commit cycle
    wait_cnt(31);
    wr(1, 15);
    tick();
    chk("late_pend_kept", 1, 0, 2);
    wait_cnt(31);
    chk("late_pend_frame", 1, 0, 2);
    tick();
    chk("late_pend_cleared", 1, 0, 0);
    chk("late_old_level", 2, 1, 4);
    chk("late_ch0_kept", 2, 0, 26);
    tick();
    wait_cnt(0);
    chk("late_new_level", 2, 1, 15);
    chk("late_ch0_still", 2, 0, 26);

    // Single-channel instance: out-of-range writes, levels 31 and 0
    wait_cnt(2);
    wr1(0, 31);
    wait_cnt(6);
    wr1(1, 0);
    tick();
    chk("s_pend_set", 4, 0, 1);
    wait_cnt(31);
    tick();
    chk("s_pend_cleared", 4, 0, 0);
    wait_cnt(4);
    wr1(1, 0);
    tick();
    chk("s_oob_no_pend", 4, 0, 0);
    tick();
    wait_cnt(0);
    chk("s_ones_31", 5, 0, 31);
    wait_cnt(3);
    wr1(0, 0);
    wait_cnt(31);
    tick();
    chk("s_ones_31_again", 5, 0, 31);
    tick();
    wait_cnt(0);
    chk("s_ones_0", 5, 0, 0);

    // en low for 3 cycles, twice: restart must be bit-exact
    for (int r = 0; r < 2; r++) begin
      en = 1'b0;
      tick();
      chk("enlow_pdm_a", 0, 0, 0);
`ifdef PDM_FRAME_STB_EN
      chk("enlow_stb", 3, 0, 0);
`endif
      wr(1, 15);
      tick();
      chk("enlow_pend_set", 1, 0, 2);
      chk("enlow_pdm_b", 0, 0, 0);
      tick();
      chk("enlow_pend_commit", 1, 0, 0);
      chk("enlow_pdm_c", 0, 0, 0);
      en = 1'b1;
      for (int k = 0; k < 11; k++) begin
        tick();
        chk("restart_seq", 0, 0, seq[k]);
      end
    end

    // Asynchronous reset mid-frame with a pending write
    wr(1, 26);
    tick();
    chk("pre_rst_pend", 1, 0, 2);
    chk("pre_rst_pdm", 0, 0, 1);
    tick();
    #2;
    reset = 1'b0;
    tcnt  = 0;
    #1;
    n_cmp++;
    if (pdm_out !== 2'b00) begin
      n_bad++;
      $display("FAIL async_rst_pdm_direct: actual %b, required 00", pdm_out);
    end
    n_cmp++;
    if (pending !== 2'b00) begin
      n_bad++;
      $display("FAIL async_rst_pend_direct: actual %b, required 00", pending);
    end
    n_cmp++;
    if (pdm1 !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst_pdm1_direct: actual %b, required 0", pdm1);
    end
    chk("async_rst_pdm", 0, 0, 0);
    chk("async_rst_pend", 1, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    wait_cnt(0);
    tick();
    wait_cnt(0);
    chk("post_rst_ones0", 2, 0, 0);
    chk("post_rst_ones1", 2, 1, 0);
    chk("post_rst_pend", 1, 0, 0);
`ifdef PDM_FRAME_STB_EN
    chk("post_rst_stb", 3, 0, 1);
`endif

    tick();
    tick();
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cyc %0d): actual never sampled, required %0d", sb[0].name, sb[0].due,
               sb[0].exp);
      sb.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
